// File: rtl/decode_pkg.sv
// rtl/decode_pkg.sv - FSM states, field encodings and control decode for decode_pipe
package decode_pkg;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_SQUASH = 2'd1,
    ST_HALTED = 2'd2
  } state_t;

  // regDst: which instruction field names the destination register
  localparam logic [1:0] DST_RD_R = 2'b00;  // instr[4:2]
  localparam logic [1:0] DST_LINK = 2'b01;  // link register
  localparam logic [1:0] DST_RS   = 2'b10;  // instr[10:8]
  localparam logic [1:0] DST_RD_I = 2'b11;  // instr[7:5]

  // whichImm: immediate source field
  localparam logic [1:0] IMM_11 = 2'b00;
  localparam logic [1:0] IMM_5  = 2'b01;
  localparam logic [1:0] IMM_8  = 2'b10;

  // branchOp: condition tested on rd1
  localparam logic [1:0] BR_EQZ = 2'b00;
  localparam logic [1:0] BR_NEZ = 2'b01;
  localparam logic [1:0] BR_LTZ = 2'b10;
  localparam logic [1:0] BR_GEZ = 2'b11;

  localparam int LINK_REG_DEF = 7;

  typedef struct packed {
    logic [1:0] reg_dst;
    logic       reg_write;
    logic [1:0] which_imm;
    logic       to_ext;
    logic       jump;
    logic       jump_reg;
    logic       branch;
    logic [1:0] branch_op;
    logic       mem_read;
    logic       halt;
    logic       err;
  } ctrl_t;

  // Control decode from the 5-bit opcode in instr[15:11]
  function automatic ctrl_t control(input logic [4:0] op);
    ctrl_t c;
    c = '0;
    casez (op)
      5'b00000: c.halt = 1'b1;
      5'b00001: c.err = 1'b0;  // nop
      5'b00100: c.jump = 1'b1;
      5'b00110: begin c.jump = 1'b1; c.reg_write = 1'b1; c.reg_dst = DST_LINK; end
      5'b00101: begin c.jump_reg = 1'b1; c.which_imm = IMM_8; end
      5'b00111: begin
        c.jump_reg = 1'b1; c.which_imm = IMM_8; c.reg_write = 1'b1; c.reg_dst = DST_LINK;
      end
      5'b0100?: begin c.reg_write = 1'b1; c.reg_dst = DST_RD_I; c.which_imm = IMM_5; c.to_ext = 1'b1; end
      5'b0101?, 5'b101??: begin c.reg_write = 1'b1; c.reg_dst = DST_RD_I; c.which_imm = IMM_5; end
      5'b011??: begin c.branch = 1'b1; c.which_imm = IMM_8; c.branch_op = op[1:0]; end
      5'b10000: begin c.which_imm = IMM_5; c.to_ext = 1'b1; end
      5'b10001: begin
        c.reg_write = 1'b1; c.reg_dst = DST_RD_I; c.which_imm = IMM_5; c.to_ext = 1'b1; c.mem_read = 1'b1;
      end
      5'b10011: begin c.reg_write = 1'b1; c.reg_dst = DST_RS; c.which_imm = IMM_5; c.to_ext = 1'b1; end
      5'b10010, 5'b11000: begin c.reg_write = 1'b1; c.reg_dst = DST_RS; c.which_imm = IMM_8; end
      5'b11001, 5'b11011, 5'b111??: begin c.reg_write = 1'b1; c.reg_dst = DST_RD_R; end
      default: c.err = 1'b1;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/decode_hazard.sv
// rtl/decode_hazard.sv - load-use hazard detection and decode ready generation
module decode_hazard (
  input  logic       run,
  input  logic       ex_stall,
  input  logic       ex_valid,
  input  logic       ex_memread,
  input  logic       ex_regwrite,
  input  logic [2:0] ex_writereg,
  input  logic [2:0] rs,
  input  logic [2:0] rt,
  input  logic       wb_conflict,
  output logic       id_ready
);
  logic hazard;

  // A load still in EX cannot hand its result to a reader in ID this cycle
  always_comb begin
    hazard   = ex_valid & ex_memread & ex_regwrite & ((ex_writereg == rs) | (ex_writereg == rt));
    id_ready = run & ~ex_stall & ~hazard & ~wb_conflict;
  end
endmodule

// File: rtl/decode_pipe.sv
// rtl/decode_pipe.sv - decode stage with register file, branch resolve and ID/EX register (option BYPASS_EN)
module decode_pipe
  import decode_pkg::*;
#(
  parameter int DATA_W        = 16,
  parameter int LINK_REG      = LINK_REG_DEF,
  parameter int HALT_MASK_CYC = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_valid,
  input  logic [15:0]       if_instr,
  input  logic [DATA_W-1:0] if_pc,
  output logic              id_ready,
  input  logic              wb_write,
  input  logic [2:0]        wb_reg,
  input  logic [DATA_W-1:0] wb_data,
  input  logic              ex_stall,
  output logic              ex_valid,
  output logic [15:0]       ex_instr,
  output logic [DATA_W-1:0] ex_rd1,
  output logic [DATA_W-1:0] ex_rd2,
  output logic [DATA_W-1:0] ex_imm,
  output logic [DATA_W-1:0] ex_link_pc,
  output logic [2:0]        ex_writereg,
  output logic              ex_regwrite,
  output logic              ex_memread,
  output logic              redirect,
  output logic [DATA_W-1:0] redirect_pc,
  output logic              halted,
  output logic              err
);
  localparam logic [2:0] LINK = 3'(LINK_REG);
  localparam int MCW = $clog2(HALT_MASK_CYC + 1) + 1;
  localparam logic [MCW-1:0] MASK_MAX = MCW'(HALT_MASK_CYC);

  state_t            state, state_nxt;
  ctrl_t             ctl;
  logic [DATA_W-1:0] regs [8];
  logic [MCW-1:0]    mask_cnt;
  logic [2:0]        rs, rt, writereg;
  logic [DATA_W-1:0] rd1, rd2, imm, target;
  logic              wb_hit_rs, wb_hit_rt, wb_conflict, accept, cond, taken, halt_now;

  assign rs        = if_instr[10:8];
  assign rt        = if_instr[7:5];
  assign ctl       = control(if_instr[15:11]);
  assign wb_hit_rs = wb_write && (wb_reg == rs);
  assign wb_hit_rt = wb_write && (wb_reg == rt);

`ifdef BYPASS_EN
  assign rd1         = wb_hit_rs ? wb_data : regs[rs];
  assign rd2         = wb_hit_rt ? wb_data : regs[rt];
  assign wb_conflict = 1'b0;
`else
  // Without forwarding, a reader of the register being written waits one cycle
  assign rd1         = regs[rs];
  assign rd2         = regs[rt];
  assign wb_conflict = wb_hit_rs | wb_hit_rt;
`endif

  decode_hazard u_hazard (
    .run         (state == ST_RUN),
    .ex_stall    (ex_stall),
    .ex_valid    (ex_valid),
    .ex_memread  (ex_memread),
    .ex_regwrite (ex_regwrite),
    .ex_writereg (ex_writereg),
    .rs          (rs),
    .rt          (rt),
    .wb_conflict (wb_conflict),
    .id_ready    (id_ready)
  );

  assign accept   = if_valid & id_ready;
  assign halt_now = accept & ctl.halt & (mask_cnt >= MASK_MAX);
  assign target   = ctl.jump_reg ? rd1 + imm : if_pc + imm;
  assign taken    = ctl.jump | ctl.jump_reg | (ctl.branch & cond);
  assign halted   = (state == ST_HALTED);

  // Immediate extraction and extension to the datapath width
  always_comb begin
    case (ctl.which_imm)
      IMM_11:  imm = {{(DATA_W-11){if_instr[10]}}, if_instr[10:0]};
      IMM_5:   imm = {{(DATA_W-5){ctl.to_ext & if_instr[4]}}, if_instr[4:0]};
      default: imm = {{(DATA_W-8){if_instr[7]}}, if_instr[7:0]};
    endcase
  end

  // Destination register and branch condition
  always_comb begin
    case (ctl.reg_dst)
      DST_RD_I: writereg = if_instr[7:5];
      DST_RD_R: writereg = if_instr[4:2];
      DST_LINK: writereg = LINK;
      default:  writereg = if_instr[10:8];
    endcase
    case (ctl.branch_op)
      BR_EQZ:  cond = (rd1 == '0);
      BR_NEZ:  cond = (rd1 != '0);
      BR_LTZ:  cond = rd1[DATA_W-1];
      default: cond = ~rd1[DATA_W-1];
    endcase
  end

  // Sequencing: a taken transfer squashes one wrong-path slot, a live halt parks the stage
  always_comb begin
    state_nxt = state;
    case (state)
      ST_RUN: begin
        if (halt_now)            state_nxt = ST_HALTED;
        else if (accept && taken) state_nxt = ST_SQUASH;
      end
      ST_SQUASH: state_nxt = ST_RUN;
      default:   state_nxt = ST_HALTED;
    endcase
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_RUN;
    else      state <= state_nxt;
  end

  // Halt mask counter, saturating once halts become live
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                     mask_cnt <= '0;
    else if (mask_cnt != MASK_MAX) mask_cnt <= mask_cnt + 1'b1;
  end

  // Register file write port
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 8; i++) regs[i] <= '0;
    end else if (wb_write) begin
      regs[wb_reg] <= wb_data;
    end
  end

  // ID/EX register: load on accept, bubble otherwise, frozen while execute stalls
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ex_valid    <= 1'b0;
      ex_instr    <= '0;
      ex_rd1      <= '0;
      ex_rd2      <= '0;
      ex_imm      <= '0;
      ex_link_pc  <= '0;
      ex_writereg <= '0;
      ex_regwrite <= 1'b0;
      ex_memread  <= 1'b0;
    end else if (!ex_stall) begin
      ex_valid <= accept;
      if (accept) begin
        ex_instr    <= if_instr;
        ex_rd1      <= rd1;
        ex_rd2      <= rd2;
        ex_imm      <= imm;
        ex_link_pc  <= if_pc;
        ex_writereg <= writereg;
        ex_regwrite <= ctl.reg_write;
        ex_memread  <= ctl.mem_read;
      end
    end
  end

  // Fetch redirect pulse and target
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      redirect    <= 1'b0;
      redirect_pc <= '0;
    end else begin
      redirect <= accept & taken;
      if (accept && taken) redirect_pc <= target;
    end
  end

  // Sticky illegal-instruction flag
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                 err <= 1'b0;
    else if (accept && ctl.err) err <= 1'b1;
  end

endmodule

// File: doc/decode_pipe.md
Name: decode_pipe

Overview:
- Parametrised successor to the single-cycle decode stage of the 16-bit pipelined processor.
- Decodes one 16-bit instruction per cycle, reads the internal register file and resolves branches and jumps in decode.
- Detects load-use hazards and inserts bubbles. Owns the ID/EX pipeline register, with valid/ready handshakes toward fetch and execute.
- Sits between fetch (IF/ID) and execute, and adds stall, squash and halt sequencing that the old decode lacked.

Parameters:
DATA_W, 16, datapath width (≥16); register, immediate and PC width
LINK_REG, 7, register written by link instructions (regDst=01)
HALT_MASK_CYC, 1, cycles after reset release during which decoded halts are ignored

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-low reset
if_valid  in  1  fetch presents an instruction
if_instr  in  16  instruction
if_pc  in  DATA_W  PC+2 of the instruction
id_ready  out  1  decode accepts the instruction this cycle
wb_write  in  1  writeback register write enable
wb_reg  in  3  writeback register
wb_data  in  DATA_W  writeback data
ex_stall  in  1  execute holds the ID/EX register
ex_valid  out  1  ID/EX holds a real instruction
ex_instr  out  16  instruction forwarded to execute
ex_rd1, ex_rd2  out  DATA_W  register operands (rs, rt)
ex_imm  out  DATA_W  extended immediate
ex_link_pc  out  DATA_W  if_pc of the instruction
ex_writereg  out  3  destination register
ex_regwrite, ex_memread  out  1  control bits
redirect  out  1  one-cycle pulse: fetch must load redirect_pc
redirect_pc  out  DATA_W  branch or jump target
halted  out  1  sticky halt
err  out  1  sticky error

Behaviour:
- Reset (rst=0, async): all ex_* outputs 0, redirect=0, redirect_pc=0, halted=0, err=0, register file all zero, FSM=RUN, mask counter=0.
- Control decode uses the existing control module; fields used: regDst, regWrite, whichImm, toExt, jump, jumpReg, branch, branchOp, memRead, halt, err.
- Destination register by regDst: 11→instr[7:5], 00→instr[4:2], 01→LINK_REG, 10→instr[10:8].
- Immediate by whichImm:
  - 00: sign-extend instr[10:0].
  - 01: instr[4:0], sign-extended if toExt, else zero-extended.
  - 10: sign-extend instr[7:0].
  - All extensions are to DATA_W.
- hazard = ex_valid & ex_memread & ex_regwrite & (ex_writereg==instr[10:8] | ex_writereg==instr[7:5]).
- Acceptance: accept = if_valid & id_ready, where id_ready = (FSM==RUN) & ~ex_stall & ~hazard.
- Priority: rst > HALTED > ex_stall > SQUASH > hazard > accept.
- ID/EX update (when ex_stall=0):
  - On accept: load the decoded bundle and set ex_valid=1.
  - Otherwise: ex_valid=0 (bubble); the other ex_* fields may hold stale values.
  - When ex_stall=1, ID/EX holds unchanged.
- Branch condition on rd1: branchOp 00 zero, 01 nonzero, 10 rd1[DATA_W-1]=1, 11 rd1[DATA_W-1]=0.
- Taken = jump | jumpReg | (branch & condition).
- Targets, all mod 2^DATA_W:
  - jumpReg: rd1+imm.
  - Otherwise: if_pc+imm.
- On acceptance of a taken instruction: next cycle redirect=1 for exactly one cycle with redirect_pc registered, and FSM→SQUASH.
- SQUASH: id_ready=0, so the wrong-path instruction on if_* is dropped. FSM→RUN next cycle regardless of if_valid.
- Halt: an accepted instruction with halt=1, when the mask counter ≥ HALT_MASK_CYC, is forwarded to execute. FSM→HALTED and halted=1 from the next cycle.
  - In HALTED: id_ready=0, ex_valid goes to 0 once ex_stall=0. Only reset exits.
- Register file: write on the clk edge when wb_write=1; all 8 registers are writable. Read is combinational from instr[10:8] and instr[7:5].
- err: set on accept when control err=1; sticky until reset.
- Mask counter: saturating, increments each cycle after reset release.

Optional Feature:
- BYPASS_EN defined: a read whose select equals wb_reg while wb_write=1 returns wb_data in the same cycle.
- Undefined: reads return stored values. id_ready is additionally forced 0 when wb_write & (wb_reg==instr[10:8] | wb_reg==instr[7:5]), giving a one-cycle stall (no bubble counted as hazard).

Decomposition:
- Package decode_pkg: FSM state encoding (RUN, SQUASH, HALTED), regDst/whichImm/branchOp encodings, LINK_REG default.
- Sub-module decode_hazard: combinational hazard and id_ready generation.

Test Plan:
- Reset mid-stream with ex_valid=1, redirect=1 → all outputs 0 immediately; first instruction is accepted on the cycle after release.
- Load to r3 in EX, next instruction reads r3 → id_ready=0 one cycle, ex_valid=0 bubble, then accepted with the correct rd1.
- BEQZ r1 with r1=0, if_pc=0x0010, imm=+4 → redirect=1 next cycle with redirect_pc=0x0014; the following if_valid instruction is dropped (ex_valid=0).
- JR with r2=0xFFFE, imm=4, DATA_W=16 → redirect_pc=0x0002 (wrap).
- Halt decoded in cycle 0 after reset → ignored. Halt decoded at cycle 5 → halted=1 at cycle 6; id_ready stays 0 for 20 further cycles.
- wb writes r4=0x1234 while decoding a read of r4 → with BYPASS_EN ex_rd1=0x1234 in one cycle; without, one stall cycle then 0x1234.
